// File: rtl/seq_normalizer_if.sv
// Start/done handshake bundle for the normalizer: request side (start, din, arith)
// and result side (busy, done, dout, shamt, zero).
interface seq_normalizer_if #(
    parameter int WIDTH = 8
);
    localparam int SW = $clog2(WIDTH);

    logic             start;
    logic [WIDTH-1:0] din;
    logic             arith;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout;
    logic [SW-1:0]    shamt;
    logic             zero;

    modport master (
        output start, din, arith,
        input  busy, done, dout, shamt, zero
    );

    modport slave (
        input  start, din, arith,
        output busy, done, dout, shamt, zero
    );
endinterface

// File: rtl/seq_normalizer.sv
// Bit-serial normalizer: finds the left shift that brings a value to unsigned
// (MSB set) or signed (top two bits differ) normal form, one bit per cycle.
module seq_normalizer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    seq_normalizer_if.slave  bus
);
    localparam int SW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [WIDTH-1:0] w_r, w_nxt_s;
    logic             mode_r, mode_nxt_s;
    logic [SW-1:0]    count_r, count_nxt_s;
    logic [WIDTH-1:0] dout_r, dout_nxt_s;
    logic [SW-1:0]    shamt_r, shamt_nxt_s;
    logic             zero_r, zero_nxt_s;
    logic             busy_r, done_r;
    logic             stop_s;

    // Stop test on the working value for the captured mode
    always_comb begin
        stop_s = 1'b0;
        if (mode_r) begin
            stop_s = w_r[WIDTH-1] ^ w_r[WIDTH-2];
        end else begin
            stop_s = w_r[WIDTH-1];
        end
    end

    // Next-state and datapath decisions; DONE accepts a new start like IDLE
    always_comb begin
        state_nxt_s = state_r;
        w_nxt_s     = w_r;
        mode_nxt_s  = mode_r;
        count_nxt_s = count_r;
        dout_nxt_s  = dout_r;
        shamt_nxt_s = shamt_r;
        zero_nxt_s  = zero_r;
        case (state_r)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_nxt_s     = bus.din;
                    mode_nxt_s  = bus.arith;
                    count_nxt_s = {SW{1'b0}};
                    if (bus.din == {WIDTH{1'b0}}) begin
                        state_nxt_s = DONE;
                        dout_nxt_s  = {WIDTH{1'b0}};
                        shamt_nxt_s = {SW{1'b0}};
                        zero_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = SHIFT;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (stop_s) begin
                    state_nxt_s = DONE;
                    dout_nxt_s  = w_r;
                    shamt_nxt_s = count_r;
                    zero_nxt_s  = 1'b0;
                end else begin
                    w_nxt_s     = {w_r[WIDTH-2:0], 1'b0};
                    count_nxt_s = count_r + SW'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, working registers and registered handshake/result outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            w_r     <= {WIDTH{1'b0}};
            mode_r  <= 1'b0;
            count_r <= {SW{1'b0}};
            dout_r  <= {WIDTH{1'b0}};
            shamt_r <= {SW{1'b0}};
            zero_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            w_r     <= w_nxt_s;
            mode_r  <= mode_nxt_s;
            count_r <= count_nxt_s;
            dout_r  <= dout_nxt_s;
            shamt_r <= shamt_nxt_s;
            zero_r  <= zero_nxt_s;
            busy_r  <= (state_nxt_s == SHIFT);
            done_r  <= (state_nxt_s == DONE);
        end
    end

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.dout  = dout_r;
    assign bus.shamt = shamt_r;
    assign bus.zero  = zero_r;
endmodule

// File: doc/seq_normalizer.md
# seq_normalizer

Multi-cycle normalizer that performs the inverse of the datapath shifter. Given a value, it finds the left-shift amount that normalizes it and returns both that amount and the normalized value. Unsigned mode shifts until the MSB is 1. Signed mode shifts until the top two bits differ. It works one bit per cycle under a start/done handshake, and feeds the FP/fixed-point datapath beside the barrel shifter.

## Interface
Parameters:
- WIDTH, 8, data width; power of two, ≥ 4

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- din  input  WIDTH  value to normalize; captured on accepted start
- arith  input  1  1 = signed (two's-complement) normalization, 0 = unsigned; captured with din
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse; result valid
- dout  output  WIDTH  normalized value
- shamt  output  $clog2(WIDTH)  left-shift count applied
- zero  output  1  input had no normalizable bit (all zeros)

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE**, start=1:
  - capture din into work register w and arith into mode; count=0.
  - If din==0, go to DONE with zero=1, dout=0, shamt=0.
  - Otherwise go to SHIFT.
- **SHIFT**, one decision per cycle. Stop condition:
  - unsigned: w[WIDTH-1]==1
  - signed: w[WIDTH-1]!=w[WIDTH-2]
- **SHIFT** actions:
  - Stop true: load dout=w, shamt=count, zero=0; go to DONE.
  - Stop false: w <= w<<1 (zero fill), count <= count+1.
- **SHIFT termination:**
  - Nonzero input always terminates with count ≤ WIDTH-1; no wrap logic is needed.
  - Signed all-ones input (-1) terminates at count=WIDTH-1 with dout=1000…0.
- **DONE:**
  - done=1 for exactly this cycle.
  - start=1 here is accepted as in IDLE (back-to-back).
  - Otherwise go to IDLE.
- Result outputs (dout, shamt, zero) hold their last values from DONE until the next result load. They are not cleared on return to IDLE.
- start while in SHIFT is ignored; din/arith changes during SHIFT have no effect.
- Invariant when zero=0: dout == (din << shamt) truncated to WIDTH.

## Timing
- Reset (synchronous, at clock edge with reset=1), from any state including mid-SHIFT:
  - state=IDLE
  - busy=0, done=0
  - dout=0, shamt=0, zero=0
  - any in-flight operation is discarded, with no done pulse.
- Edge numbering: edge 0 is the edge that samples start=1.
- Nonzero input with result k:
  - SHIFT occupies cycles after edges 0…k.
  - done is high after edge k+1.
  - Latency start→done = k+2 cycles.
  - busy is high for k+1 cycles.
- Zero input: done is high after edge 0 (latency 1); busy is never asserted.
- done and busy are never high together.
- dout/shamt/zero change only on the edge that enters DONE or on reset.
- Max throughput: one result per k+2 cycles, using start in DONE.

## Test plan
- **Unsigned extremes:** WIDTH=8, arith=0, din=0x01 → shamt=7, dout=0x80, zero=0, done 9 cycles after start, busy 8 cycles. Then din=0x80 → shamt=0, dout=0x80, done 2 cycles after start.
- **Zero input:** din=0x00, both modes → zero=1, dout=0x00, shamt=0, done 1 cycle after start, busy never high.
- **Signed:**
  - arith=1, din=0xF3 → shamt=3, dout=0x98
  - din=0x05 → shamt=4, dout=0x50
  - din=0xFF → shamt=7, dout=0x80
  - din=0x40 → shamt=0, dout=0x40
- **Handshake:**
  - start held high continuously with din=0x10 → results repeat every 5 cycles (back-to-back via DONE).
  - start pulsed during SHIFT with different din → ignored; result matches the original din.
- **Reset mid-op:** start din=0x01, assert reset after 3 cycles → next cycle all outputs 0, IDLE, no done pulse. A new start din=0x20 then completes with shamt=2, dout=0x80.
- **Random sweep:** 1000 random din/arith → check the invariant dout==(din<<shamt) and the stop condition on dout. Also check that no smaller shift satisfies the stop condition, and that latency equals shamt+2.
